// File: rtl/regfile_pkg.sv
// Shared defaults and type aliases for the register file with issue scoreboard.
// Data words are MSB-first: bit 0 is the most significant bit.
package regfile_pkg;

    localparam int unsigned DATA_W   = 128;
    localparam int unsigned NUM_REGS = 128;
    localparam int unsigned MAX_LAT  = 7;

    typedef logic [0:DATA_W-1]               reg_data_t;
    typedef logic [$clog2(NUM_REGS)-1:0]     reg_addr_t;
    typedef logic [$clog2(MAX_LAT+1)-1:0]    lat_t;

endpackage

// File: rtl/regfile_sb_counter.sv
// One register's reservation down-counter: saturating decrement, issue load
// (kept as the larger of the decremented count and the new latency), flush clear.
module regfile_sb_counter #(
    parameter int unsigned LAT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_load,
    input  logic [LAT_W-1:0] i_load_val,
    output logic             o_busy
);

    logic [LAT_W-1:0] r_cnt;
    logic [LAT_W-1:0] w_dec;

    assign w_dec = (r_cnt == '0) ? '0 : r_cnt - LAT_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_flush) begin
            r_cnt <= '0;
        end else if (i_load && (i_load_val > w_dec)) begin
            r_cnt <= i_load_val;
        end else begin
            r_cnt <= w_dec;
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with write-to-read bypass and a per-register
// latency scoreboard driven by issue reservations.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
    parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int unsigned NUM_RD   = 6,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned MAX_LAT  = regfile_pkg::MAX_LAT,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned LAT_W    = $clog2(MAX_LAT + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_rd_addr  [NUM_RD],
    output logic [0:DATA_W-1] o_rd_data  [NUM_RD],
    output logic              o_rd_busy  [NUM_RD],
    input  logic              i_wr_en    [NUM_WR],
    input  logic [ADDR_W-1:0] i_wr_addr  [NUM_WR],
    input  logic [0:DATA_W-1] i_wr_data  [NUM_WR],
    input  logic              i_iss_en   [NUM_WR],
    input  logic [ADDR_W-1:0] i_iss_addr [NUM_WR],
    input  logic [LAT_W-1:0]  i_iss_lat  [NUM_WR],
    input  logic              i_flush
);

    logic [0:DATA_W-1] r_mem  [NUM_REGS];
    logic              w_busy [NUM_REGS];

    // Later non-blocking assignments override earlier ones, so the highest
    // write port wins on an address collision.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (i_wr_en[w] && (32'(i_wr_addr[w]) < NUM_REGS)) begin
                    r_mem[i_wr_addr[w]] <= i_wr_data[w];
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
        logic             w_load;
        logic [LAT_W-1:0] w_val;

        always_comb begin
            w_load = 1'b0;
            w_val  = '0;
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (i_iss_en[w] && (32'(i_iss_addr[w]) == r) &&
                    (i_iss_lat[w] != '0) && (32'(i_iss_lat[w]) <= MAX_LAT)) begin
                    w_load = 1'b1;
                    if (i_iss_lat[w] > w_val) w_val = i_iss_lat[w];
                end
            end
        end

        regfile_sb_counter #(.LAT_W(LAT_W)) u_cnt (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_flush    (i_flush),
            .i_load     (w_load),
            .i_load_val (w_val),
            .o_busy     (w_busy[r])
        );
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [0:DATA_W-1] w_data;
        logic              w_bsy;

        // Bypass is gated by reset so the port reads zero while reset is held.
        always_comb begin
            w_data = '0;
            w_bsy  = 1'b0;
            if (32'(i_rd_addr[p]) < NUM_REGS) begin
                w_data = r_mem[i_rd_addr[p]];
                w_bsy  = w_busy[i_rd_addr[p]];
                if (i_rst_n) begin
                    for (int unsigned w = 0; w < NUM_WR; w++) begin
                        if (i_wr_en[w] && (i_wr_addr[w] == i_rd_addr[p])) begin
                            w_data = i_wr_data[w];
                            w_bsy  = 1'b0;
                        end
                    end
                end
            end
        end

        assign o_rd_data[p] = w_data;
        assign o_rd_busy[p] = w_bsy;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Random and directed checks of regfile_scoreboard against a model that tracks
// each register's value and the edge number at which its reservation expires.
module tb_regfile_scoreboard;

    localparam int NR = 100;
    localparam int RD = 6;
    localparam int WR = 2;
    localparam int DW = 128;
    localparam int AW = 7;
    localparam int LW = 3;
    localparam int ML = 7;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] rd_addr  [RD];
    logic [0:DW-1] rd_data  [RD];
    logic          rd_busy  [RD];
    logic          wr_en    [WR];
    logic [AW-1:0] wr_addr  [WR];
    logic [0:DW-1] wr_data  [WR];
    logic          iss_en   [WR];
    logic [AW-1:0] iss_addr [WR];
    logic [LW-1:0] iss_lat  [WR];
    logic          flush;

    int n_checks = 0;
    int n_errors = 0;

    logic [0:DW-1] m_mem   [NR];
    int            m_until [NR];
    int            m_n;

    regfile_scoreboard #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .NUM_RD   (RD),
        .NUM_WR   (WR),
        .MAX_LAT  (ML)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_rd_busy  (rd_busy),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_iss_en   (iss_en),
        .i_iss_addr (iss_addr),
        .i_iss_lat  (iss_lat),
        .i_flush    (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_mem[r]   = '0;
            m_until[r] = 0;
        end
        m_n = 0;
    endtask

    task automatic clear_inputs();
        for (int w = 0; w < WR; w++) begin
            wr_en[w] = 1'b0; wr_addr[w] = '0; wr_data[w] = '0;
            iss_en[w] = 1'b0; iss_addr[w] = '0; iss_lat[w] = '0;
        end
        flush = 1'b0;
    endtask

    task automatic check_reads();
        for (int p = 0; p < RD; p++) begin
            int            a;
            logic [0:DW-1] ed;
            logic          eb;
            a  = int'(rd_addr[p]);
            ed = '0;
            eb = 1'b0;
            if (a < NR) begin
                ed = m_mem[a];
                eb = (m_until[a] > m_n);
                if (rst_n) begin
                    for (int w = 0; w < WR; w++) begin
                        if (wr_en[w] && int'(wr_addr[w]) == a) begin
                            ed = wr_data[w];
                            eb = 1'b0;
                        end
                    end
                end
            end
            chk($sformatf("rd%0d_data@%0d", p, a), rd_data[p], ed);
            chk($sformatf("rd%0d_busy@%0d", p, a), 128'(rd_busy[p]), 128'(eb));
        end
    endtask

    task automatic model_edge();
        if (!rst_n) return;
        m_n++;
        for (int w = 0; w < WR; w++) begin
            if (wr_en[w] && int'(wr_addr[w]) < NR) m_mem[wr_addr[w]] = wr_data[w];
        end
        if (flush) begin
            for (int r = 0; r < NR; r++) m_until[r] = 0;
        end else begin
            for (int w = 0; w < WR; w++) begin
                if (iss_en[w] && int'(iss_addr[w]) < NR &&
                    iss_lat[w] != 0 && int'(iss_lat[w]) <= ML) begin
                    if (m_n + int'(iss_lat[w]) > m_until[iss_addr[w]])
                        m_until[iss_addr[w]] = m_n + int'(iss_lat[w]);
                end
            end
        end
    endtask

    task automatic step();
        #1;
        check_reads();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 9) == 0) return AW'($urandom_range(NR - 10, 127));
        return AW'($urandom_range(0, 15));
    endfunction

    task automatic set_rd_all(input int a);
        for (int p = 0; p < RD; p++) rd_addr[p] = AW'(a);
    endtask

    logic [0:DW-1] d1, d2, d3;

    initial begin
        d1 = 128'h03F8A1B9E2C7F1A5B3D6E9C2F5A8B1C4;
        d2 = 128'h0A7E5F23D6C9B1A4E5F2C7F1A5B3D6E9;
        d3 = 128'h01B3A5C7E9A2B4D6F8C9E2A4B6D8F1A5;

        clear_inputs();
        set_rd_all(0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 chk("reset_busy", 128'(rd_busy[0]), 128'(0));
        chk("reset_data", rd_data[0], '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset during a write to reg 5
        set_rd_all(5);
        wr_en[0] = 1'b1; wr_addr[0] = 7'd5; wr_data[0] = d1;
        step();
        wr_data[0] = d2;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reads();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        step();
        chk("r036_data", rd_data[0], '0);
        chk("r036_busy", 128'(rd_busy[3]), 128'(0));

        // Same-cycle bypass, then stored value
        wr_en[0] = 1'b1; wr_addr[0] = 7'd5; wr_data[0] = d1;
        #1 chk("r037_bypass", rd_data[2], d1);
        step();
        clear_inputs();
        #1 chk("r037_stored", rd_data[2], d1);
        step();

        // Two ports to the same register: port 1 wins
        wr_en[0] = 1'b1; wr_addr[0] = 7'd5; wr_data[0] = d2;
        wr_en[1] = 1'b1; wr_addr[1] = 7'd5; wr_data[1] = d3;
        #1 chk("r038_bypass", rd_data[1], d3);
        step();
        clear_inputs();
        #1 chk("r038_stored", rd_data[1], d3);
        step();

        // Latency-4 reservation on reg 7
        set_rd_all(7);
        iss_en[0] = 1'b1; iss_addr[0] = 7'd7; iss_lat[0] = 3'd4;
        step();
        clear_inputs();
        for (int k = 0; k <= 4; k++) begin
            #1 chk($sformatf("r039_busy_k%0d", k), 128'(rd_busy[0]), 128'(k < 4));
            step();
        end
        iss_en[0] = 1'b1; iss_addr[0] = 7'd7; iss_lat[0] = 3'd4;
        step();
        clear_inputs();
        step();
        step();
        wr_en[1] = 1'b1; wr_addr[1] = 7'd7; wr_data[1] = d2;
        #1 chk("r039_wr_clears_busy", 128'(rd_busy[4]), 128'(0));
        step();
        clear_inputs();
        repeat (3) step();

        // Reg 9: lat 6 then lat 2 keeps the longer reservation
        set_rd_all(9);
        iss_en[0] = 1'b1; iss_addr[0] = 7'd9; iss_lat[0] = 3'd6;
        step();
        iss_lat[0] = 3'd2;
        step();
        clear_inputs();
        for (int k = 0; k <= 5; k++) begin
            #1 chk($sformatf("r040_busy_k%0d", k), 128'(rd_busy[1]), 128'(k < 5));
            step();
        end
        iss_en[1] = 1'b1; iss_addr[1] = 7'd9; iss_lat[1] = 3'd0;
        step();
        clear_inputs();
        #1 chk("r040_lat0", 128'(rd_busy[1]), 128'(0));
        step();

        // Flush clears reservations but keeps data
        rd_addr[0] = 7'd3; rd_addr[1] = 7'd4; rd_addr[2] = 7'd10;
        wr_en[0] = 1'b1; wr_addr[0] = 7'd3; wr_data[0] = d1;
        wr_en[1] = 1'b1; wr_addr[1] = 7'd4; wr_data[1] = d3;
        step();
        clear_inputs();
        iss_en[0] = 1'b1; iss_addr[0] = 7'd3; iss_lat[0] = 3'd7;
        iss_en[1] = 1'b1; iss_addr[1] = 7'd4; iss_lat[1] = 3'd7;
        step();
        iss_en[0] = 1'b1; iss_addr[0] = 7'd10; iss_lat[0] = 3'd7; iss_en[1] = 1'b0;
        step();
        clear_inputs();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1 chk("r041_busy3", 128'(rd_busy[0]), 128'(0));
        chk("r041_busy10", 128'(rd_busy[2]), 128'(0));
        chk("r041_data3", rd_data[0], d1);
        chk("r041_data4", rd_data[1], d3);
        step();

        // Out-of-range register: writes and issues ignored, reads zero
        set_rd_all(NR + 3);
        wr_en[0] = 1'b1; wr_addr[0] = AW'(NR + 3); wr_data[0] = d2;
        iss_en[0] = 1'b1; iss_addr[0] = AW'(NR + 3); iss_lat[0] = 3'd5;
        #1 chk("oor_bypass", rd_data[0], '0);
        step();
        clear_inputs();
        #1 chk("oor_data", rd_data[0], '0);
        chk("oor_busy", 128'(rd_busy[0]), 128'(0));
        step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < RD; p++) rd_addr[p] = rnd_addr();
            for (int w = 0; w < WR; w++) begin
                wr_en[w]    = ($urandom_range(0, 2) == 0);
                wr_addr[w]  = rnd_addr();
                wr_data[w]  = {$urandom(), $urandom(), $urandom(), $urandom()};
                iss_en[w]   = ($urandom_range(0, 1) == 0);
                iss_addr[w] = rnd_addr();
                iss_lat[w]  = LW'($urandom_range(0, 7));
            end
            flush = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_W, default 128, register width in bits; bit 0 is MSB on all data ports.
REQ-002 Parameter NUM_REGS, default 128, number of architectural registers.
REQ-003 Parameter NUM_RD, default 6, number of read ports.
REQ-004 Parameter NUM_WR, default 2, number of write/issue ports; higher index is later in program order.
REQ-005 Parameter MAX_LAT, default 7, largest reservation latency in cycles.
REQ-006 Derived: ADDR_W = clog2(NUM_REGS); LAT_W = clog2(MAX_LAT+1).
REQ-007 clock  input  1  single clock; all state updates on its rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 rd_addr[NUM_RD]  input  ADDR_W  read-port register addresses.
REQ-010 rd_data[NUM_RD]  output  DATA_W  read-port data.
REQ-011 rd_busy[NUM_RD]  output  1  scoreboard busy flag for each rd_addr.
REQ-012 wr_en[NUM_WR]  input  1  writeback strobe per port.
REQ-013 wr_addr[NUM_WR]  input  ADDR_W  writeback destination.
REQ-014 wr_data[NUM_WR]  input  DATA_W  writeback value.
REQ-015 iss_en[NUM_WR]  input  1  destination reservation strobe at issue.
REQ-016 iss_addr[NUM_WR]  input  ADDR_W  reserved destination.
REQ-017 iss_lat[NUM_WR]  input  LAT_W  cycles until result writeback.
REQ-018 flush  input  1  synchronous clear of all reservations.

Function
REQ-019 Reads are combinational: rd_data = stored value of rd_addr, with zero latency.
REQ-020 Bypass: if wr_en[w] and wr_addr[w]==rd_addr in the same cycle, rd_data = wr_data[w].
REQ-021 Among matching write ports, the highest index wins for both bypass and storage.
REQ-022 Storage update: at the rising edge, each enabled write port stores wr_data into wr_addr, resolved by REQ-021.
REQ-023 rd_addr >= NUM_RD... correction: rd_addr >= NUM_REGS returns zero data and rd_busy=0; writes and issues to such addresses are ignored.
REQ-024 Scoreboard: each register has a LAT_W down-counter cnt; busy(r) = (cnt[r] != 0).
REQ-025 Each edge: a nonzero cnt decrements by 1, unless it is loaded by an issue in that cycle.
REQ-026 Issue: iss_en with iss_lat = L, where 1 <= L <= MAX_LAT, loads cnt = max(cnt-1 saturating at 0, L). The register is busy for exactly L cycles after the issuing edge.
REQ-027 iss_lat = 0 or iss_lat > MAX_LAT: no reservation is made; the register is unaffected.
REQ-028 Same-address issue on multiple ports in one cycle: load the maximum of all candidate values.
REQ-029 rd_busy is forced to 0 combinationally when any wr_en in the same cycle targets rd_addr; this pairs with the data bypass.
REQ-030 flush: at the edge, all cnt are set to 0, and issues in that cycle are discarded. The register array is unaffected, and writes in that cycle still commit.

Reset
REQ-031 reset low immediately sets all registers to 0 and all cnt to 0; rd_data reflects 0 and rd_busy = 0 while reset is held.
REQ-032 Reset asserted mid-operation drops any in-flight write or issue of that cycle. Operation resumes on the first rising edge after reset deasserts.

Structure
REQ-033 Package regfile_pkg holds the default constants DATA_W, NUM_REGS and MAX_LAT, plus the typedefs reg_data_t, reg_addr_t and lat_t.
REQ-034 Sub-module regfile_sb_counter implements one register's down-counter with issue load and flush; it is instantiated NUM_REGS times.
REQ-035 The array and bypass muxes are coded with generate loops over NUM_RD and NUM_WR; there is no hard-coded port count.

Verification
REQ-036 Assert reset low during a wr_en to reg 5 -> after release, read reg 5 = 0 and all rd_busy = 0.
REQ-037 Port0 writes reg 5 = 0x03F8A1B9E2C7F1A5B3D6E9C2F5A8B1C4 and port2 reads reg 5 in the same cycle -> bypassed value is seen immediately; it is still returned next cycle with wr_en low.
REQ-038 Port0 writes reg 5 = 0x0A7E5F23D6C9B1A4E5F2C7F1A5B3D6E9 and port1 writes reg 5 = 0x01B3A5C7E9A2B4D6F8C9E2A4B6D8F1A5 in the same cycle -> same-cycle read and later reads both return the port1 value.
REQ-039 Issue reg 7 with lat 4 at edge 0 -> rd_busy=1 after edges 0-3 and 0 after edge 4. A repeat with wr_en to reg 7 after edge 2 -> rd_busy=0 combinationally in that cycle.
REQ-040 Issue reg 9 with lat 6, then issue reg 9 with lat 2 one cycle later -> cnt=5, busy for 5 more cycles. Issue with lat 0 -> reg 9 never busy.
REQ-041 Reserve regs 3, 4 and 10 (lat 7), then pulse flush -> all rd_busy=0 after the edge, and stored values are unchanged.
